ship_motion: RTL and testbench



---
 rtl/ship_motion.sv | 173 +++++++++++++++++
 tb/tb_ship_motion.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ship_motion.sv
// Per-frame ship state engine: rotation, thrust, drag and wrapped position update,
// followed by a plot handshake with the sprite drawer.
module ship_motion #(
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 240,
  parameter int MAX_SPEED   = 48,
  parameter int ROT_DIV     = 4,
  parameter int DRAG_PERIOD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       rot_left,
  input  logic       rot_right,
  input  logic       thrust,
  input  logic       draw_done,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [5:0] direction,
  output logic       plot,
  output logic       busy
);

  localparam int ROT_W  = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;
  localparam int DRAG_W = (DRAG_PERIOD > 1) ? $clog2(DRAG_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, UPDATE, PLOT, WAIT_DONE} state_t;

  state_t            state_reg;
  logic [3:0]        heading_reg;
  logic [ROT_W-1:0]  rot_cnt_reg;
  logic [DRAG_W-1:0] drag_cnt_reg;
  logic              plot_reg;
  logic              busy_reg;

  logic              update_en;
  logic              drag_hit;
  logic              rot_one;
  logic signed [2:0] thrust_d [2];
  logic [9:0]        pos_px [2];

  // Heading-vector ROM shared with draw_ship: {x_neg, |dx|, y_up, |dy|}.
  always_comb begin
    direction = 6'b000111;
    case (heading_reg)
      4'd0:  direction = 6'b000111;
      4'd1:  direction = 6'b001111;
      4'd2:  direction = 6'b011111;
      4'd3:  direction = 6'b011101;
      4'd4:  direction = 6'b011000;
      4'd5:  direction = 6'b011001;
      4'd6:  direction = 6'b011011;
      4'd7:  direction = 6'b001011;
      4'd8:  direction = 6'b000011;
      4'd9:  direction = 6'b101011;
      4'd10: direction = 6'b111011;
      4'd11: direction = 6'b111001;
      4'd12: direction = 6'b111000;
      4'd13: direction = 6'b111101;
      4'd14: direction = 6'b111111;
      4'd15: direction = 6'b101111;
      default: direction = 6'b000111;
    endcase
  end

  // Thrust vector always comes from the heading held before this frame's rotation.
  assign thrust_d[0] = direction[5] ? -$signed({1'b0, direction[4:3]}) : $signed({1'b0, direction[4:3]});
  assign thrust_d[1] = direction[2] ? -$signed({1'b0, direction[1:0]}) : $signed({1'b0, direction[1:0]});

  assign update_en = (state_reg == UPDATE);
  assign drag_hit  = (drag_cnt_reg == DRAG_W'(DRAG_PERIOD - 1));
  assign rot_one   = rot_left ^ rot_right;

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    localparam logic signed [15:0] SPAN    = 16'((gi == 0 ? SCREEN_W : SCREEN_H) * 16);
    localparam logic [13:0]        POS_RST = 14'((gi == 0 ? 144 : 104) * 16);
    localparam logic signed [8:0]  VMAX    = 9'(MAX_SPEED);

    logic signed [7:0]  vel_reg;
    logic signed [7:0]  vel_next;
    logic [13:0]        pos_reg;
    logic [13:0]        pos_next;
    logic signed [8:0]  vel_sum;
    logic signed [15:0] pos_sum;

    always_comb begin
      vel_sum  = {vel_reg[7], vel_reg} + {{6{thrust_d[gi][2]}}, thrust_d[gi]};
      vel_next = vel_reg;
      if (thrust) begin
        if (vel_sum > VMAX)
          vel_next = VMAX[7:0];
        else if (vel_sum < -VMAX)
          vel_next = 8'(-VMAX);
        else
          vel_next = vel_sum[7:0];
      end else if (drag_hit) begin
        if (vel_reg > 8'sd0)
          vel_next = vel_reg - 8'sd1;
        else if (vel_reg < 8'sd0)
          vel_next = vel_reg + 8'sd1;
      end
      // |v| <= 127 sub-pixels, so one wrap correction is always enough.
      pos_sum = {2'b00, pos_reg} + {{8{vel_next[7]}}, vel_next};
      if (pos_sum < 16'sd0)
        pos_sum = pos_sum + SPAN;
      else if (pos_sum >= SPAN)
        pos_sum = pos_sum - SPAN;
      pos_next = pos_sum[13:0];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vel_reg <= '0;
        pos_reg <= POS_RST;
      end else if (update_en) begin
        vel_reg <= vel_next;
        pos_reg <= pos_next;
      end
    end

    assign pos_px[gi] = pos_reg[13:4];
  end

  assign x_pos = pos_px[0];
  assign y_pos = pos_px[1];
  assign plot  = plot_reg;
  assign busy  = busy_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      heading_reg  <= '0;
      rot_cnt_reg  <= '0;
      drag_cnt_reg <= '0;
      plot_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      plot_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (frame_tick) begin
            state_reg <= UPDATE;
            busy_reg  <= 1'b1;
          end
        end
        UPDATE: begin
          state_reg <= PLOT;
          plot_reg  <= 1'b1;
          if (rot_one) begin
            if (rot_cnt_reg == '0)
              heading_reg <= heading_reg + (rot_right ? 4'd1 : 4'd15);
            rot_cnt_reg <= (rot_cnt_reg == ROT_W'(ROT_DIV - 1)) ? '0 : rot_cnt_reg + 1'b1;
          end else begin
            rot_cnt_reg <= '0;
          end
          if (thrust || drag_hit)
            drag_cnt_reg <= '0;
          else
            drag_cnt_reg <= drag_cnt_reg + 1'b1;
        end
        PLOT: state_reg <= WAIT_DONE;
        WAIT_DONE: begin
          if (draw_done) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ship_motion.sv
// Scoreboard bench for ship_motion: a behavioural ship model pushes expected sprite
// state per frame, compared when the DUT raises plot.
module tb_ship_motion;

  localparam int SCREEN_W = 320, SCREEN_H = 240, MAX_SPEED = 48, ROT_DIV = 4, DRAG_PERIOD = 8;

  logic clk = 1'b0, reset = 1'b1;
  logic frame_tick = 1'b0, rot_left = 1'b0, rot_right = 1'b0, thrust = 1'b0, draw_done = 1'b0;
  logic [9:0] x_pos, y_pos;
  logic [5:0] direction;
  logic plot, busy;

  int checks = 0;
  int errors = 0;
  int frame_no = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [5:0] d;
  } exp_t;
  exp_t sb[$];

  logic [5:0] dir_table [16] = '{6'b000111, 6'b001111, 6'b011111, 6'b011101,
                                 6'b011000, 6'b011001, 6'b011011, 6'b001011,
                                 6'b000011, 6'b101011, 6'b111011, 6'b111001,
                                 6'b111000, 6'b111101, 6'b111111, 6'b101111};

  int m_heading, m_vx, m_vy, m_px, m_py, m_rot, m_drag;

  ship_motion #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .MAX_SPEED(MAX_SPEED),
                .ROT_DIV(ROT_DIV), .DRAG_PERIOD(DRAG_PERIOD)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .rot_left(rot_left),
    .rot_right(rot_right), .thrust(thrust), .draw_done(draw_done), .x_pos(x_pos),
    .y_pos(y_pos), .direction(direction), .plot(plot), .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_heading = 0; m_vx = 0; m_vy = 0; m_px = 144 * 16; m_py = 104 * 16; m_rot = 0; m_drag = 0;
    sb.delete();
  endtask

  function automatic int clamp_v(input int v);
    if (v > MAX_SPEED) return MAX_SPEED;
    if (v < -MAX_SPEED) return -MAX_SPEED;
    return v;
  endfunction

  function automatic int toward_zero(input int v);
    if (v > 0) return v - 1;
    if (v < 0) return v + 1;
    return v;
  endfunction

  function automatic int wrap(input int p, input int span);
    if (p < 0) return p + span;
    if (p >= span) return p - span;
    return p;
  endfunction

  task automatic model_step(input bit rl, input bit rr, input bit th);
    logic [5:0] dv;
    int dxs, dys;
    exp_t e;
    dv = dir_table[m_heading];
    dxs = int'(dv[4:3]);
    if (dv[5]) dxs = -dxs;
    dys = int'(dv[1:0]);
    if (dv[2]) dys = -dys;
    if (rl != rr) begin
      if (m_rot == 0) m_heading = (m_heading + (rr ? 1 : 15)) % 16;
      m_rot = (m_rot + 1) % ROT_DIV;
    end else begin
      m_rot = 0;
    end
    if (th) begin
      m_vx = clamp_v(m_vx + dxs);
      m_vy = clamp_v(m_vy + dys);
      m_drag = 0;
    end else if (m_drag == DRAG_PERIOD - 1) begin
      m_vx = toward_zero(m_vx);
      m_vy = toward_zero(m_vy);
      m_drag = 0;
    end else begin
      m_drag++;
    end
    m_px = wrap(m_px + m_vx, SCREEN_W * 16);
    m_py = wrap(m_py + m_vy, SCREEN_H * 16);
    e.x = 10'(m_px / 16);
    e.y = 10'(m_py / 16);
    e.d = dir_table[m_heading];
    sb.push_back(e);
  endtask

  task automatic finish_draw();
    @(negedge clk); draw_done = 1'b1;
    @(negedge clk); draw_done = 1'b0;
  endtask

  // Drives one frame and captures the sprite state at the plot strobe.
  task automatic run_frame(input bit rl, input bit rr, input bit th, input bit finish,
                           output logic [9:0] ox, output logic [9:0] oy,
                           output logic [5:0] od, output bit got);
    got = 1'b0; ox = '0; oy = '0; od = '0;
    @(negedge clk);
    rot_left = rl; rot_right = rr; thrust = th; frame_tick = 1'b1;
    model_step(rl, rr, th);
    @(negedge clk);
    frame_tick = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (plot === 1'b1) begin
        got = 1'b1; ox = x_pos; oy = y_pos; od = direction;
      end
    end
    frame_no++;
    $display("frame %0d: rl=%0d rr=%0d th=%0d plot_seen=%0d x=%0d y=%0d dir=%b",
             frame_no, rl, rr, th, got, ox, oy, od);
    if (finish) finish_draw();
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    frame_tick = 1'b0; rot_left = 1'b0; rot_right = 1'b0; thrust = 1'b0; draw_done = 1'b0;
    @(negedge clk); reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (x_pos !== 10'd144) begin errors++; $display("FAIL reset_x: got %0d want 144", x_pos); end
    checks++;
    if (y_pos !== 10'd104) begin errors++; $display("FAIL reset_y: got %0d want 104", y_pos); end
    checks++;
    if (direction !== 6'b000111) begin errors++; $display("FAIL reset_dir: got %b want 000111", direction); end
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: got plot=%b busy=%b want 0 0", plot, busy);
    end
  endtask

  task automatic test_latency();
    exp_t e;
    bit bad;
    @(negedge clk);
    rot_left = 1'b0; rot_right = 1'b0; thrust = 1'b0; frame_tick = 1'b1;
    model_step(1'b0, 1'b0, 1'b0);
    @(negedge clk); frame_tick = 1'b0;
    checks++;
    if (busy !== 1'b1 || plot !== 1'b0) begin
      errors++; $display("FAIL lat_n1: got busy=%b plot=%b want 1 0", busy, plot);
    end
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (plot !== 1'b1 || x_pos !== e.x || y_pos !== e.y || direction !== e.d || x_pos !== 10'd144 || y_pos !== 10'd104) begin
      errors++;
      $display("FAIL lat_n2: got plot=%b x=%0d y=%0d dir=%b want plot=1 x=%0d y=%0d dir=%b",
               plot, x_pos, y_pos, direction, e.x, e.y, e.d);
    end
    @(negedge clk);
    checks++;
    if (plot !== 1'b0) begin errors++; $display("FAIL lat_n3_plot: got %b want 0", plot); end
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      frame_tick = (i == 10);
      if (busy !== 1'b1 || plot !== 1'b0 || x_pos !== e.x || y_pos !== e.y) bad = 1'b1;
    end
    frame_tick = 1'b0;
    checks++;
    if (bad) begin errors++; $display("FAIL ignored_tick: got disturbance=1 want 0"); end
    draw_done = 1'b1;
    @(negedge clk); draw_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL done_idle: got busy=%b want 0", busy); end
    $display("frame latency test: busy dropped after draw_done");
  endtask

  task automatic test_rotate();
    logic [9:0] ox, oy;
    logic [5:0] od;
    bit got;
    exp_t e;
    for (int f = 1; f <= 8; f++) begin
      run_frame(1'b0, 1'b1, 1'b0, 1'b1, ox, oy, od, got);
      e = sb.pop_front();
      checks++;
      if (!got || ox !== e.x || oy !== e.y || od !== e.d) begin
        errors++;
        $display("FAIL rot_right f%0d: got seen=%0d x=%0d y=%0d dir=%b want x=%0d y=%0d dir=%b",
                 f, got, ox, oy, od, e.x, e.y, e.d);
      end
      if (f == 1 || f == 5) begin
        checks++;
        if (od !== ((f == 1) ? 6'b001111 : 6'b011111)) begin
          errors++; $display("FAIL rot_step f%0d: got %b", f, od);
        end
      end
    end
    for (int f = 1; f <= 2; f++) begin
      run_frame(1'b1, 1'b1, 1'b0, 1'b1, ox, oy, od, got);
      e = sb.pop_front();
      checks++;
      if (!got || od !== e.d || od !== 6'b011111) begin
        errors++; $display("FAIL rot_both f%0d: got seen=%0d dir=%b want %b", f, got, od, e.d);
      end
    end
  endtask

  task automatic test_thrust_and_drag();
    logic [9:0] ox, oy, prev_y;
    logic [5:0] od;
    bit got;
    exp_t e;
    do_reset();
    prev_y = 10'd104;
    for (int f = 1; f <= 20; f++) begin
      run_frame(1'b0, 1'b0, 1'b1, 1'b1, ox, oy, od, got);
      e = sb.pop_front();
      checks++;
      if (!got || ox !== e.x || oy !== e.y || od !== e.d || ox !== 10'd144) begin
        errors++;
        $display("FAIL thrust f%0d: got seen=%0d x=%0d y=%0d dir=%b want x=%0d y=%0d dir=%b",
                 f, got, ox, oy, od, e.x, e.y, e.d);
      end
      if (f == 1) begin
        checks++;
        if (oy !== 10'd103) begin errors++; $display("FAIL thrust_first_y: got %0d want 103", oy); end
      end
      if (f >= 17) begin
        checks++;
        if (((int'(prev_y) - int'(oy) + SCREEN_H) % SCREEN_H) != 3) begin
          errors++; $display("FAIL thrust_sat f%0d: got step %0d want 3", f, int'(prev_y) - int'(oy));
        end
      end
      prev_y = oy;
    end
    for (int f = 1; f <= 24; f++) begin
      run_frame(1'b0, 1'b0, 1'b0, 1'b1, ox, oy, od, got);
      e = sb.pop_front();
      checks++;
      if (!got || ox !== e.x || oy !== e.y || ox !== 10'd144) begin
        errors++;
        $display("FAIL drag f%0d: got seen=%0d x=%0d y=%0d want x=%0d y=%0d", f, got, ox, oy, e.x, e.y);
      end
    end
  endtask

  task automatic test_wrap_and_abort();
    logic [9:0] ox, oy, prev_x;
    logic [5:0] od;
    bit got, wrapped, over;
    int after;
    exp_t e;
    do_reset();
    for (int f = 1; f <= 13; f++) begin
      run_frame(1'b1, 1'b0, 1'b0, 1'b1, ox, oy, od, got);
      e = sb.pop_front();
      checks++;
      if (!got || od !== e.d) begin
        errors++; $display("FAIL rot_left f%0d: got seen=%0d dir=%b want %b", f, got, od, e.d);
      end
    end
    checks++;
    if (od !== 6'b111000) begin errors++; $display("FAIL heading12: got %b want 111000", od); end
    prev_x = 10'd144; wrapped = 1'b0; over = 1'b0; after = 0;
    for (int f = 1; f <= 80 && after < 3; f++) begin
      run_frame(1'b0, 1'b0, 1'b1, 1'b1, ox, oy, od, got);
      e = sb.pop_front();
      checks++;
      if (!got || ox !== e.x || oy !== e.y || od !== e.d) begin
        errors++;
        $display("FAIL wrap f%0d: got seen=%0d x=%0d y=%0d want x=%0d y=%0d", f, got, ox, oy, e.x, e.y);
      end
      if (ox >= 10'(SCREEN_W)) over = 1'b1;
      if (ox > prev_x) wrapped = 1'b1;
      if (wrapped) after++;
      prev_x = ox;
    end
    checks++;
    if (!wrapped || over) begin
      errors++; $display("FAIL wrap_edge: got wrapped=%0d out_of_range=%0d want 1 0", wrapped, over);
    end
    run_frame(1'b0, 1'b0, 1'b1, 1'b0, ox, oy, od, got);
    e = sb.pop_front();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (x_pos !== 10'd144 || y_pos !== 10'd104 || direction !== 6'b000111 || busy !== 1'b0 || plot !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: got x=%0d y=%0d dir=%b busy=%b plot=%b want 144 104 000111 0 0",
               x_pos, y_pos, direction, busy, plot);
    end
    @(negedge clk);
    reset = 1'b0; thrust = 1'b0;
    model_reset();
    finish_draw();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || plot !== 1'b0 || x_pos !== 10'd144) begin
      errors++; $display("FAIL late_done: got busy=%b plot=%b x=%0d want 0 0 144", busy, plot, x_pos);
    end
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, ox, oy, od, got);
    e = sb.pop_front();
    checks++;
    if (!got || ox !== e.x || oy !== e.y || od !== e.d) begin
      errors++; $display("FAIL post_reset_frame: got seen=%0d x=%0d y=%0d dir=%b", got, ox, oy, od);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_rotate();
    test_thrust_and_drag();
    test_wrap_and_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
